// File: rtl/ssm_demux.sv
// Substream demultiplexer: spreads incoming mux words over NUM_SSM show-ahead FIFOs,
// round-robin during the initial fill, then lowest-index-first on demand.
module ssm_demux #(
   parameter int NUM_SSM    = 4,
   parameter int W          = 128,
   parameter int DEPTH      = 4,
   parameter int INIT_WORDS = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 flush,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [W-1:0]         in_data,
   output logic                 in_ready,
   input  logic [NUM_SSM-1:0]   ssm_rd_en,
   output logic [NUM_SSM*W-1:0] ssm_data,
   output logic [NUM_SSM-1:0]   ssm_empty,
   output logic                 dec_ready,
   output logic [NUM_SSM-1:0]   underflow
);

   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int IW    = (NUM_SSM > 1) ? $clog2(NUM_SSM) : 1;
   localparam int TOTAL = NUM_SSM * INIT_WORDS;
   localparam int TW    = $clog2(TOTAL + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]      cnt    [NUM_SSM];
   logic [PW-1:0]      rd_ptr [NUM_SSM];
   logic [PW-1:0]      wr_ptr [NUM_SSM];
   logic [W-1:0]       mem    [NUM_SSM][DEPTH];
   logic [IW-1:0]      rr_idx;
   logic [TW-1:0]      init_cnt;

   logic [NUM_SSM-1:0] pop_ok;
   logic [NUM_SSM-1:0] uflow_hit;
   logic [NUM_SSM-1:0] needy;
   logic [NUM_SSM-1:0] wr_sel;
   logic               found;
   logic               init_last;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      return p + PW'(1);
   endfunction

   function automatic logic [IW-1:0] rr_inc(input logic [IW-1:0] r);
      if (r == IW'(NUM_SSM - 1)) return '0;
      return r + IW'(1);
   endfunction

   // Pop qualification and refill demand; demand is judged after this cycle's pop.
   always_comb begin
      pop_ok    = '0;
      uflow_hit = '0;
      needy     = '0;
      for (int i = 0; i < NUM_SSM; i++) begin
         pop_ok[i]    = ssm_rd_en[i] & (cnt[i] != '0);
         uflow_hit[i] = ssm_rd_en[i] & (cnt[i] == '0);
         needy[i]     = (cnt[i] - CW'(pop_ok[i])) < CW'(INIT_WORDS);
      end
   end

   assign init_last = (init_cnt == TW'(TOTAL - 1));

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      wr_sel    = '0;
      found     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = INIT;
         end
         INIT: begin
            in_ready       = 1'b1;
            wr_sel[rr_idx] = in_valid;
            if (in_valid && init_last) state_nxt = RUN;
         end
         RUN: begin
            in_ready = |needy;
            for (int i = 0; i < NUM_SSM; i++) begin
               if (needy[i] && !found) begin
                  found     = 1'b1;
                  wr_sel[i] = in_valid;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         in_ready  = 1'b0;
         wr_sel    = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         rr_idx    <= '0;
         init_cnt  <= '0;
         dec_ready <= 1'b0;
         underflow <= '0;
         for (int i = 0; i < NUM_SSM; i++) begin
            cnt[i]    <= '0;
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
         end
      end else if (flush) begin
         state     <= IDLE;
         rr_idx    <= '0;
         init_cnt  <= '0;
         dec_ready <= 1'b0;
         underflow <= '0;
         for (int i = 0; i < NUM_SSM; i++) begin
            cnt[i]    <= '0;
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
         end
      end else begin
         state     <= state_nxt;
         underflow <= underflow | uflow_hit;
         if (state == IDLE && start) begin
            rr_idx   <= '0;
            init_cnt <= '0;
         end
         if (state == INIT && in_valid) begin
            rr_idx   <= rr_inc(rr_idx);
            init_cnt <= init_cnt + TW'(1);
            if (init_last) dec_ready <= 1'b1;
         end
         for (int i = 0; i < NUM_SSM; i++) begin
            if (wr_sel[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
            if (pop_ok[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
            case ({wr_sel[i], pop_ok[i]})
               2'b10:   cnt[i] <= cnt[i] + CW'(1);
               2'b01:   cnt[i] <= cnt[i] - CW'(1);
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

   // Word storage carries no reset; empty slots are masked on the output.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SSM; i++) begin
         if (wr_sel[i]) mem[i][wr_ptr[i]] <= in_data;
      end
   end

   always_comb begin
      ssm_data  = '0;
      ssm_empty = '0;
      for (int i = 0; i < NUM_SSM; i++) begin
         ssm_empty[i] = (cnt[i] == '0);
         if (cnt[i] != '0) ssm_data[i*W +: W] = mem[i][rd_ptr[i]];
      end
   end

endmodule

// File: tb/tb_ssm_demux.sv
// Directed bench for ssm_demux: initial fill, refill priority, simultaneous
// pop/write, underflow, flush mid-fill and asynchronous reset.
module tb_ssm_demux;

   localparam int NUM_SSM = 4;
   localparam int W       = 128;

   logic                 clk;
   logic                 rstn;
   logic                 flush;
   logic                 start;
   logic                 in_valid;
   logic [W-1:0]         in_data;
   logic                 in_ready;
   logic [NUM_SSM-1:0]   ssm_rd_en;
   logic [NUM_SSM*W-1:0] ssm_data;
   logic [NUM_SSM-1:0]   ssm_empty;
   logic                 dec_ready;
   logic [NUM_SSM-1:0]   underflow;

   int n_chk;
   int n_err;

   ssm_demux #(
      .NUM_SSM(NUM_SSM), .W(W), .DEPTH(4), .INIT_WORDS(2)
   ) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ssm_rd_en(ssm_rd_en), .ssm_data(ssm_data), .ssm_empty(ssm_empty),
      .dec_ready(dec_ready), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] head(input int i);
      return ssm_data[i*W +: W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] word);
      in_valid = 1'b1;
      in_data  = word;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop(input logic [NUM_SSM-1:0] mask);
      ssm_rd_en = mask;
      tick();
      ssm_rd_en = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      n_chk     = 0;
      n_err     = 0;
      rstn      = 1'b0;
      flush     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      ssm_rd_en = '0;

      #12;
      check("rst_in_ready",  W'(in_ready),  W'(0));
      check("rst_dec_ready", W'(dec_ready), W'(0));
      check("rst_underflow", W'(underflow), W'(0));
      check("rst_empty",     W'(ssm_empty), W'(4'hF));
      check("rst_data",      ssm_data[W-1:0] | ssm_data[2*W-1:W] | ssm_data[3*W-1:2*W] | ssm_data[4*W-1:3*W], '0);
      rstn = 1'b1;
      tick();

      // Initial round-robin fill
      pulse_start();
      check("init_in_ready", W'(in_ready), W'(1));
      for (int k = 1; k <= 8; k++) begin
         push(W'(k));
         check("fill_dec_ready", W'(dec_ready), W'(k == 8));
      end
      check("fill_in_ready", W'(in_ready), W'(0));
      check("fill_empty", W'(ssm_empty), W'(0));
      for (int i = 0; i < NUM_SSM; i++) check("fill_head", head(i), W'(i + 1));

      // Single refill of FIFO1
      ssm_rd_en = 4'b0010;
      #1;
      check("refill_ready_on_pop", W'(in_ready), W'(1));
      tick();
      ssm_rd_en = '0;
      check("refill_head1_after_pop", head(1), W'(6));
      check("refill_in_ready", W'(in_ready), W'(1));
      push(W'(9));
      check("refill_in_ready_drop", W'(in_ready), W'(0));
      check("refill_head1_keep", head(1), W'(6));

      // Priority: FIFO0 before FIFO3
      pop(4'b1001);
      check("prio_head0", head(0), W'(5));
      check("prio_head3", head(3), W'(8));
      push(W'(8'h0A));
      push(W'(8'h0B));
      check("prio_in_ready", W'(in_ready), W'(0));
      pop(4'b1001);
      check("prio_word0", head(0), W'(8'h0A));
      check("prio_word3", head(3), W'(8'h0B));
      push(W'(8'h0D));
      push(W'(8'h0E));

      // Simultaneous pop and write on FIFO2
      pop(4'b0100);
      check("sim_head2_pre", head(2), W'(7));
      ssm_rd_en = 4'b0100;
      in_valid  = 1'b1;
      in_data   = W'(8'h0C);
      #1;
      check("sim_in_ready", W'(in_ready), W'(1));
      tick();
      ssm_rd_en = '0;
      in_valid  = 1'b0;
      check("sim_head2", head(2), W'(8'h0C));
      check("sim_empty", W'(ssm_empty), W'(0));
      check("sim_count_one", W'(in_ready), W'(1));
      push(W'(8'h0F));
      check("sim_full_again", W'(in_ready), W'(0));

      // Underflow on FIFO2
      pop(4'b0100);
      check("uf_head2_next", head(2), W'(8'h0F));
      pop(4'b0100);
      check("uf_empty2", W'(ssm_empty), W'(4'b0100));
      check("uf_data2_zero", head(2), W'(0));
      check("uf_none_yet", W'(underflow), W'(0));
      pop(4'b0100);
      check("uf_set", W'(underflow), W'(4'b0100));
      ssm_rd_en = 4'b0100;
      in_valid  = 1'b1;
      in_data   = W'(8'h10);
      tick();
      ssm_rd_en = '0;
      in_valid  = 1'b0;
      check("uf_write_kept", head(2), W'(8'h10));
      check("uf_sticky", W'(underflow), W'(4'b0100));
      check("uf_dec_ready", W'(dec_ready), W'(1));

      // Flush, then flush mid-INIT
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_underflow", W'(underflow), W'(0));
      check("flush_dec_ready", W'(dec_ready), W'(0));
      check("flush_empty", W'(ssm_empty), W'(4'hF));
      check("flush_in_ready", W'(in_ready), W'(0));
      pulse_start();
      for (int k = 0; k < 3; k++) push(W'(8'h21 + k));
      check("midinit_head0", head(0), W'(8'h21));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("midinit_empty", W'(ssm_empty), W'(4'hF));
      check("midinit_dec_ready", W'(dec_ready), W'(0));
      check("midinit_in_ready", W'(in_ready), W'(0));
      pulse_start();
      for (int k = 0; k < 8; k++) push(W'(8'h31 + k));
      check("refill_dec_ready", W'(dec_ready), W'(1));
      for (int i = 0; i < NUM_SSM; i++) check("refill_head", head(i), W'(8'h31 + i));
      pop(4'hF);
      for (int i = 0; i < NUM_SSM; i++) check("multi_pop_head", head(i), W'(8'h35 + i));
      check("multi_pop_in_ready", W'(in_ready), W'(1));

      // Asynchronous reset mid-operation
      rstn = 1'b0;
      #1;
      check("arst_empty", W'(ssm_empty), W'(4'hF));
      check("arst_dec_ready", W'(dec_ready), W'(0));
      check("arst_in_ready", W'(in_ready), W'(0));
      rstn = 1'b1;
      tick();
      check("arst_idle", W'(in_ready), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
